// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter that owns the select of a shared mux.
// A grant lasts for a whole packet, which ends when the granted requester's last beat is accepted.
module rr_mux_arbiter #(
    parameter int NUM_REQ   = 32,
    parameter int SEL_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   last,
    input  logic                 out_ready,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 out_valid,
    output logic                 busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q, state_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] prio_q, prio_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;

    logic [SEL_WIDTH-1:0] cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   cand_hit;
    logic [SEL_WIDTH-1:0] win_idx;
    logic                 win_found;
    logic                 xfer;

    // Candidate gi is the requester at distance gi+1 past the last winner,
    // wrapped modulo NUM_REQ so out-of-range indices can never be produced.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SEL_WIDTH:0] sum;
            assign sum = {1'b0, prio_q} + (SEL_WIDTH+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (SEL_WIDTH+1)'(NUM_REQ))
                                ? SEL_WIDTH'(sum - (SEL_WIDTH+1)'(NUM_REQ))
                                : sum[SEL_WIDTH-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        // Walk from the farthest candidate inward so the nearest hit wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                win_idx   = cand_idx[i];
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            prio_q  <= SEL_WIDTH'(NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
        end
    end

    assign xfer = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    sel_d   = win_idx;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                end
            end
            BUSY: begin
                if (xfer && last[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    prio_d  = sel_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset suppresses the handshake so an aborted packet shows no accept pulse.
    always_comb begin
        busy      = (state_q == BUSY);
        sel       = sel_q;
        gnt       = gnt_q;
        out_valid = busy & req[sel_q] & ~rst;
        req_ready = gnt_q & {NUM_REQ{out_valid & out_ready}};
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one `mux_generic` instance between `NUM_REQ` requesters. It owns the mux `sel` input. It grants a single requester for a whole packet, which is one or more beats ended by that requester's `last` flag. While a packet is in progress it passes the valid/ready handshake between the granted requester and the downstream consumer. It sits in front of any shared datapath port where several lanes or warps contend for one output bus.

## Interface
- `NUM_REQ`, 32, number of requesters; must be ≥ 2.
- `SEL_WIDTH`, `$clog2(NUM_REQ)`, width of the mux select.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  `NUM_REQ`  per-requester valid; high while that requester has a beat to send.
- `last`  in  `NUM_REQ`  per-requester end-of-packet flag; sampled only for the granted requester.
- `out_ready`  in  1  downstream accepts the current beat.
- `sel`  out  `SEL_WIDTH`  registered index of the granted requester; drives the mux `sel`.
- `gnt`  out  `NUM_REQ`  registered one-hot grant; all zeros when idle.
- `req_ready`  out  `NUM_REQ`  per-requester beat-accepted strobe: `gnt & {NUM_REQ{out_valid & out_ready}}`.
- `out_valid`  out  1  `busy & req[sel]`.
- `busy`  out  1  high while in state BUSY.

## Operation
- Two states: IDLE and BUSY.
- Round-robin pointer `prio` is registered, `SEL_WIDTH` bits wide, and holds the index of the last winner.
- Search order starts at `prio+1` and wraps modulo `NUM_REQ`. The first set bit of `req` in that order wins.
- IDLE:
  - If `req` is all zeros, stay in IDLE.
  - Otherwise register the winner into `sel`, set its `gnt` bit, and go to BUSY.
- BUSY:
  - A transfer happens when `out_valid & out_ready`.
  - A transfer with `last[sel]=1` ends the packet. Next cycle: state IDLE, `gnt` all zeros, `prio <= sel`.
  - A transfer with `last[sel]=0` keeps the grant.
  - If the granted requester deasserts `req` mid-packet, `out_valid` goes low. The grant is held with no timeout, and no other requester is considered until `last` is accepted.
  - Requests from non-granted requesters are ignored in BUSY.
- `sel` holds its value in IDLE. Only `gnt` and `busy` indicate idleness.
- Indices ≥ `NUM_REQ` never appear on `sel`, including when `NUM_REQ` is not a power of two. The wrap is modulo `NUM_REQ`, not 2^`SEL_WIDTH`.
- Reset values:
  - state IDLE.
  - `sel=0`, `gnt=0`, `busy=0`.
  - `prio=NUM_REQ-1`, so requester 0 has highest priority after reset.
  - Combinational outputs `out_valid` and `req_ready` are therefore 0.
- Reset asserted mid-packet aborts the packet immediately. The next cycle shows the reset values, with no `req_ready` pulse in the reset cycle.

## Timing
- Arbitration latency: a request sampled in IDLE at edge t produces `gnt`/`sel` valid and `busy=1` after edge t.
  - `out_valid` can be high in cycle t+1.
- Single-beat packets cost 2 cycles per packet: one cycle in IDLE, one transfer cycle. There is one mandatory bubble between packets.
- An N-beat packet with `out_ready` held high takes N+1 cycles.
- `out_valid`, `req_ready` and `out_ready` form a combinational path. `sel`, `gnt`, `busy` and `prio` are purely registered.
- `sel` is stable for the whole of BUSY, so the mux output is glitch-free per packet.
- `req_ready` depends combinationally on `out_ready` and `req`. Requesters must not make `req` depend on `req_ready` in the same cycle.

## Test plan
All scenarios use `NUM_REQ=4` unless stated.
- **Reset, then contention:** after reset, `req=4'b1111` with `last` high everywhere and `out_ready=1`. Required grant order 0,1,2,3,0, with `gnt` high on alternate cycles and `sel` = 0,1,2,3,0.
- **Multi-beat hold:**
  - Requester 2 sends 3 beats with `last` on beat 3, while `req[0]` stays high.
  - `sel` stays 2 for 3 transfer cycles and `req_ready[0]` stays 0.
  - Requester 0 is granted in the cycle after the IDLE bubble.
- **Backpressure and req drop:**
  - `out_ready=0` for 5 cycles mid-packet: no `req_ready`, `sel` held.
  - `req[sel]` dropped for 2 cycles: `out_valid=0`, state stays BUSY.
- **Wrap with a gap:** `prio=3`, `req=4'b0100`. Winner is 2, then `prio=2`. Next `req=4'b0011` grants 0 before 1.
- **Non-power-of-two:** `NUM_REQ=5`, all requesting single beats. Order is 0..4 then 0, and `sel` never exceeds 4.
- **Reset mid-packet:** `rst` asserted during beat 2 of 4. The next cycle shows IDLE, `gnt=0`, `sel=0`. With `req=4'b1000` afterwards, requester 3 is granted.
